// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store
// with round-robin arbitration, one-cycle completion pulses and fetch cancellation.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_cancel_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_valid_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              stall_if_o,
    output logic              stall_mem_o
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;
    state_t state_q, state_d;
    logic last_dm_q, last_dm_d, drop_q, drop_d;
    logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic dm_elig, if_elig, grant_dm, grant_if;

    // A requester in its valid cycle is still holding req; it must not be re-granted.
    assign dm_elig  = dm_req_i && !dm_valid_q;
    assign if_elig  = if_req_i && !if_valid_q && !if_cancel_i;
    assign grant_dm = dm_elig && (!if_elig || !last_dm_q);
    assign grant_if = if_elig && !grant_dm;

    always_comb begin
        state_d     = state_q;
        last_dm_d   = last_dm_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        case (state_q)
            IDLE: if (grant_dm || grant_if) begin
                state_d     = grant_dm ? DM_BUSY : IF_BUSY;
                last_dm_d   = grant_dm;
                mem_req_d   = 1'b1;
                mem_we_d    = grant_dm && dm_we_i;
                mem_addr_d  = grant_dm ? dm_addr_i : if_addr_i;
                mem_wdata_d = grant_dm ? dm_wdata_i : mem_wdata_q;
            end
            IF_BUSY: if (mem_ready_i) begin
                state_d    = IDLE;
                mem_req_d  = 1'b0;
                drop_d     = 1'b0;
                if_valid_d = !(drop_q || if_cancel_i);
                if_rdata_d = (drop_q || if_cancel_i) ? if_rdata_q : mem_rdata_i;
            end else if (if_cancel_i) begin
                drop_d = 1'b1;
            end
            DM_BUSY: if (mem_ready_i) begin
                state_d    = IDLE;
                mem_req_d  = 1'b0;
                dm_valid_d = 1'b1;
                dm_rdata_d = mem_we_q ? dm_rdata_q : mem_rdata_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            last_dm_q   <= 1'b0;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dm_q   <= last_dm_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign if_valid_o  = if_valid_q;
    assign dm_valid_o  = dm_valid_q;
    assign stall_if_o  = if_req_i && !if_valid_q;
    assign stall_mem_o = dm_req_i && !dm_valid_q;
endmodule
